// File: rtl/rx_frame_controller.sv
// rtl/rx_frame_controller.sv - QPSK frame sequencer: lock tracking, frame admission, dibit packing, byte FIFO
module rx_frame_controller #(
  parameter int FRAME_SYMS  = 63,
  parameter int FIFO_DEPTH  = 32,
  parameter int SOF_TIMEOUT = 8191,
  parameter int LOCK_CNT    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        sof_pulse,
  input  logic        sym_valid,
  input  logic [1:0]  sym_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_last,
  output logic        locked,
  output logic [15:0] frame_cnt,
  output logic [15:0] drop_cnt
);

  localparam int BPF = (FRAME_SYMS + 3) / 4;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int SW  = $clog2(FRAME_SYMS + 1);
  localparam int TW  = $clog2(SOF_TIMEOUT + 1);
  localparam logic [CW-1:0] ADMIT_MAX = CW'(FIFO_DEPTH - BPF);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] LAST_IDX  = SW'(FRAME_SYMS - 1);
  localparam logic [TW-1:0] TIMEOUT   = TW'(SOF_TIMEOUT);
  localparam logic [7:0]    LOCK_THR  = 8'(LOCK_CNT - 1);

  typedef enum logic [1:0] {SEARCH, RECV, SKIP, GAP} state_t;

  state_t        state;
  logic [SW-1:0] sym_idx;
  logic [7:0]    pack;
  logic [TW-1:0] timer;
  logic [7:0]    good_cnt;

  logic [8:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic          sof_ok, room, admit_recv, admit_skip;
  logic          recv_sym, byte_end, frame_end, push, pop;
  logic [SW-1:0] idx_eff;
  logic [7:0]    cur_byte;

  // Symbol index restarts at 0 on the admission cycle so a coincident symbol is symbol 0.
  always_comb begin
    sof_ok     = sof_pulse & en & ((state == SEARCH) | (state == GAP));
    room       = (count <= ADMIT_MAX);
    admit_recv = sof_ok & room;
    admit_skip = sof_ok & ~room;
    idx_eff    = ((state == RECV) | (state == SKIP)) ? sym_idx : '0;
    recv_sym   = sym_valid & ((state == RECV) | admit_recv);
    frame_end  = (idx_eff == LAST_IDX);
    byte_end   = (idx_eff[1:0] == 2'd3) | frame_end;
    cur_byte   = (idx_eff[1:0] == 2'd0) ? 8'h00 : pack;
    case (idx_eff[1:0])
      2'd0:    cur_byte[7:6] = sym_data;
      2'd1:    cur_byte[5:4] = sym_data;
      2'd2:    cur_byte[3:2] = sym_data;
      default: cur_byte[1:0] = sym_data;
    endcase
    push = recv_sym & byte_end;
    pop  = out_valid & out_ready;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= SEARCH;
      sym_idx   <= '0;
      pack      <= '0;
      timer     <= '0;
      good_cnt  <= '0;
      locked    <= 1'b0;
      frame_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (recv_sym) pack <= cur_byte;
      case (state)
        SEARCH, GAP: begin
          if (sof_ok) begin
            state   <= room ? RECV : SKIP;
            sym_idx <= sym_valid ? SW'(1) : '0;
            if (admit_skip && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            if (state == GAP) begin
              if (good_cnt >= LOCK_THR) locked <= 1'b1;
              if (good_cnt != 8'hFF) good_cnt <= good_cnt + 8'd1;
            end
          end else if (state == GAP) begin
            if (!en) begin
              state <= SEARCH;
            end else if (timer == TIMEOUT) begin
              state    <= SEARCH;
              locked   <= 1'b0;
              good_cnt <= '0;
            end else begin
              timer <= timer + 1'b1;
            end
          end
        end
        default: begin
          if (sym_valid) begin
            sym_idx <= sym_idx + 1'b1;
            if (frame_end) begin
              state <= GAP;
              timer <= '0;
              if (state == RECV) frame_cnt <= frame_cnt + 16'd1;
            end
          end
        end
      endcase
    end
  end

  // First-word fall-through byte FIFO; the last-byte tag rides in bit 8.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {frame_end, cur_byte};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign out_valid = (count != '0);
  assign out_data  = out_valid ? mem[rd_ptr][7:0] : 8'h00;
  assign out_last  = out_valid ? mem[rd_ptr][8] : 1'b0;

  always_ff @(posedge clk) begin
    if (rst) assert (!(push && !pop && count == FULL_CNT));
  end

endmodule

// File: tb/tb_rx_frame_controller.sv
// tb/tb_rx_frame_controller.sv - directed bench with a frame-level reference model for rx_frame_controller
module tb_rx_frame_controller;

  localparam int FRAME_SYMS  = 63;
  localparam int FIFO_DEPTH  = 32;
  localparam int SOF_TIMEOUT = 8191;
  localparam int LOCK_CNT    = 2;
  localparam int BPF         = (FRAME_SYMS + 3) / 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b1;
  logic        sof_pulse = 1'b0;
  logic        sym_valid = 1'b0;
  logic [1:0]  sym_data = 2'd0;
  logic        out_ready = 1'b1;
  logic        out_valid, out_last, locked;
  logic [7:0]  out_data;
  logic [15:0] frame_cnt, drop_cnt;

  rx_frame_controller #(
    .FRAME_SYMS(FRAME_SYMS), .FIFO_DEPTH(FIFO_DEPTH),
    .SOF_TIMEOUT(SOF_TIMEOUT), .LOCK_CNT(LOCK_CNT)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .sof_pulse(sof_pulse),
    .sym_valid(sym_valid), .sym_data(sym_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .locked(locked), .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit chk_on = 1'b0;

  // Model: 0 idle/search, 1 receiving, 2 skipping, 3 between frames
  int         m_mode = 0, m_gap = 0, m_good = 0, m_skip = 0, m_frames = 0, m_drops = 0;
  bit         m_locked = 1'b0;
  int         syms[$];
  logic [8:0] exp_q[$];
  logic [8:0] seen[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic void take(input logic [1:0] s, output bit pushed, output logic [8:0] b);
    int n;
    logic [7:0] v;
    syms.push_back(int'(s));
    n = syms.size();
    pushed = 1'b0;
    b = '0;
    if (n % 4 == 0 || n == FRAME_SYMS) begin
      v = 8'h00;
      for (int k = ((n - 1) / 4) * 4; k < n; k++) v = v | (8'(syms[k]) << (6 - 2 * (k % 4)));
      pushed = 1'b1;
      b = {n == FRAME_SYMS, v};
    end
  endfunction

  // Evaluate the model for the coming edge, apply it just after the edge.
  task automatic tick();
    int n_mode, n_gap, n_good, n_skip, n_frames, n_drops;
    bit n_locked, do_push;
    logic [8:0] pb;
    n_mode = m_mode; n_gap = m_gap; n_good = m_good; n_skip = m_skip;
    n_frames = m_frames; n_drops = m_drops; n_locked = m_locked;
    do_push = 1'b0; pb = '0;
    if (rst) begin
      case (m_mode)
        0, 3: begin
          if (sof_pulse && en) begin
            if (m_mode == 3) begin
              if (m_good >= LOCK_CNT - 1) n_locked = 1'b1;
              n_good = m_good + 1;
            end
            if (FIFO_DEPTH - exp_q.size() >= BPF) begin
              n_mode = 1;
              syms.delete();
              if (sym_valid) take(sym_data, do_push, pb);
            end else begin
              n_mode = 2;
              if (m_drops < 16'hFFFF) n_drops = m_drops + 1;
              n_skip = sym_valid ? 1 : 0;
            end
          end else if (m_mode == 3) begin
            if (!en) n_mode = 0;
            else if (m_gap == SOF_TIMEOUT) begin
              n_mode = 0; n_locked = 1'b0; n_good = 0;
            end else n_gap = m_gap + 1;
          end
        end
        1: if (sym_valid) begin
          take(sym_data, do_push, pb);
          if (syms.size() == FRAME_SYMS) begin
            n_mode = 3; n_gap = 0; n_frames = (m_frames + 1) & 16'hFFFF;
          end
        end
        default: if (sym_valid) begin
          n_skip = m_skip + 1;
          if (n_skip == FRAME_SYMS) begin
            n_mode = 3; n_gap = 0;
          end
        end
      endcase
    end
    @(posedge clk);
    #1;
    if (!rst) begin
      exp_q.delete(); syms.delete();
      m_mode = 0; m_gap = 0; m_good = 0; m_skip = 0; m_frames = 0; m_drops = 0; m_locked = 1'b0;
    end else begin
      m_mode = n_mode; m_gap = n_gap; m_good = n_good; m_skip = n_skip;
      m_frames = n_frames; m_drops = n_drops; m_locked = n_locked;
      if (do_push) exp_q.push_back(pb);
    end
  endtask

  always @(negedge clk) begin
    logic [8:0] dummy;
    if (chk_on) begin
      chk("out_valid", out_valid, exp_q.size() != 0);
      if (out_valid === 1'b1 && exp_q.size() != 0) begin
        chk("out_byte", {out_last, out_data}, exp_q[0]);
        if (out_ready) begin
          seen.push_back({out_last, out_data});
          dummy = exp_q.pop_front();
        end
      end
      chk("frame_cnt", frame_cnt, m_frames);
      chk("drop_cnt", drop_cnt, m_drops);
      chk("locked", locked, m_locked);
    end
  end

  function automatic logic [1:0] sym_of(input int pat, input int i);
    case (pat)
      0:       return 2'(i % 4);
      1:       return 2'(3 - i % 4);
      2:       return 2'((i * 3 + 1) % 4);
      default: return 2'((i / 4 + i) % 4);
    endcase
  endfunction

  task automatic idle(input int n);
    sof_pulse = 1'b0; sym_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic frame(input int pat, input bit coinc, input int spur, input int en_off, input int n);
    sof_pulse = 1'b1; sym_valid = coinc; sym_data = coinc ? sym_of(pat, 0) : 2'd0;
    tick();
    sof_pulse = 1'b0;
    for (int i = coinc ? 1 : 0; i < n; i++) begin
      sym_valid = 1'b1; sym_data = sym_of(pat, i); sof_pulse = (i == spur);
      if (i == en_off) en = 1'b0;
      tick();
    end
    sym_valid = 1'b0; sof_pulse = 1'b0;
  endtask

  initial begin
    int mark;
    int f0;
    rst = 1'b0;
    tick();
    chk_on = 1'b1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    tick();
    rst = 1'b1;
    idle(2);

    // 1: 0,1,2,3 pattern packs to 0x1B, final 3-symbol byte 0x18 tagged last
    mark = seen.size();
    frame(0, 1'b0, -1, -1, FRAME_SYMS);
    idle(5);
    chk("t1_bytes", seen.size() - mark, 16);
    chk("t1_first", seen[mark], 9'h01B);
    chk("t1_last", seen[mark + 15], 9'h118);
    chk("t1_frames", frame_cnt, 1);

    // 2: two frames fill the FIFO, third is skipped, then drain
    out_ready = 1'b0;
    mark = seen.size();
    frame(2, 1'b0, -1, -1, FRAME_SYMS);
    idle(3);
    frame(3, 1'b0, -1, -1, FRAME_SYMS);
    idle(3);
    frame(1, 1'b0, -1, -1, FRAME_SYMS);
    idle(3);
    chk("t2_drops", drop_cnt, 1);
    chk("t2_frames", frame_cnt, 3);
    out_ready = 1'b1;
    idle(40);
    chk("t2_bytes", seen.size() - mark, 32);
    chk("t2_last16", seen[mark + 15][8], 1);
    chk("t2_mid15", seen[mark + 14][8], 0);
    chk("t2_last32", seen[mark + 31][8], 1);

    // 3: lock after two completed frames, lost after the SOF timeout
    rst = 1'b0; tick(); rst = 1'b1;
    frame(0, 1'b0, -1, -1, FRAME_SYMS);
    idle(10);
    frame(2, 1'b0, -1, -1, FRAME_SYMS);
    idle(10);
    chk("t3_prelock", locked, 0);
    sof_pulse = 1'b1; tick(); sof_pulse = 1'b0;
    chk("t3_lock", locked, 1);
    for (int i = 0; i < FRAME_SYMS; i++) begin
      sym_valid = 1'b1; sym_data = sym_of(3, i); tick();
    end
    sym_valid = 1'b0;
    idle(SOF_TIMEOUT);
    chk("t3_hold", locked, 1);
    idle(1);
    chk("t3_unlock", locked, 0);
    chk("t3_frames", frame_cnt, 3);

    // 4: coincident symbol is symbol 0, spurious SOF mid-frame ignored
    mark = seen.size();
    frame(1, 1'b1, 30, -1, FRAME_SYMS);
    idle(5);
    chk("t4_first", seen[mark], 9'h0E4);
    chk("t4_bytes", seen.size() - mark, 16);
    chk("t4_last", seen[mark + 15][8], 1);
    chk("t4_frames", frame_cnt, 4);
    chk("t4_locked", locked, 0);

    // 5: en drop mid-frame completes the frame, following SOF ignored
    f0 = int'(frame_cnt);
    mark = seen.size();
    frame(3, 1'b0, -1, 20, FRAME_SYMS);
    idle(5);
    chk("t5_frames", frame_cnt, f0 + 1);
    chk("t5_bytes", seen.size() - mark, 16);
    frame(0, 1'b0, -1, -1, FRAME_SYMS);
    idle(5);
    chk("t5_ignored", frame_cnt, f0 + 1);
    chk("t5_nobytes", seen.size() - mark, 16);
    en = 1'b1;

    // 6: reset mid-frame, then a clean frame
    frame(2, 1'b0, -1, -1, 40);
    rst = 1'b0; sym_valid = 1'b1; sym_data = 2'd3;
    tick();
    rst = 1'b1; sym_valid = 1'b0;
    chk("t6_valid", out_valid, 0);
    chk("t6_frames", frame_cnt, 0);
    chk("t6_drops", drop_cnt, 0);
    mark = seen.size();
    frame(0, 1'b0, -1, -1, FRAME_SYMS);
    idle(5);
    chk("t6_first", seen[mark], 9'h01B);
    chk("t6_last", seen[mark + 15], 9'h118);
    chk("t6_clean", frame_cnt, 1);

    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
